accumulate_ctrl: RTL and testbench
==================================

# accumulate_ctrl

Fabric-side controller for the switch-accumulate datapath on the MAX10 board. It synchronizes and debounces the raw active-low accumulate push-button and adds the 8-bit switch value into a running sum exactly once per debounced press. It drives the LED bank and tracks sticky overflow, replacing software polling of the accumulate key with deterministic hardware sequencing.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a press or release (10 ms at 50 MHz). Must be ≥ 2.
- CNT_W, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50 domain).
- Reset  in  1  synchronous, active-high reset.
- Accumulate_n  in  1  raw push-button, active-low, asynchronous to Clk, bouncy.
- Clear  in  1  synchronous, active-high; zeroes the sum and overflow.
- SW  in  8  switch operand. Sampled only on the accumulate cycle.
- LED  out  8  running sum.
- Overflow  out  1  sticky flag, set when any addition carries out of bit 7.
- Acc_pulse  out  1  one-cycle strobe on each cycle the sum is updated by an accumulation.
- Busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer: two flops on Accumulate_n, both reset to 1 (released). Downstream logic uses only `pressed = ~sync2`.
- FSM states and transitions:
  - IDLE: if pressed, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT: if not pressed, go to IDLE (bounce). Else if cnt == DEBOUNCE_CYCLES-1, go to HELD and accumulate. Else cnt++.
  - HELD: if not pressed, go to RELEASE_WAIT with cnt = 0. Holding the button never re-accumulates.
  - RELEASE_WAIT: if pressed, go to HELD (bounce). Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE. Else cnt++.
- Accumulate action, on the PRESS_WAIT→HELD edge:
  - LED <= (LED + SW) mod 256.
  - If the 9-bit sum has bit 8 set, Overflow <= 1.
  - Acc_pulse = 1 for that one cycle.
- Overflow is sticky. Only Clear or Reset lowers it.
- Clear: LED <= 0 and Overflow <= 0 on the next edge. The FSM and counter are unaffected.
- Clear coinciding with an accumulate edge: Clear wins.
  - LED = 0 and Overflow = 0; the SW value is discarded.
  - Acc_pulse still asserts and the FSM still enters HELD, so the press is consumed.
- Busy = (state != IDLE).
- Reset mid-operation:
  - The FSM returns to IDLE, cnt = 0, and the synchronizer is set to released.
  - If the button is still held after Reset deasserts, it is treated as a new press and accumulates once after a full debounce.

## Timing
- Reset values: LED = 0x00, Overflow = 0, Acc_pulse = 0, Busy = 0, state IDLE, cnt = 0, sync flops = 1.
- Press latency: Accumulate_n falls and stays low before rising edge 0.
  - sync2 goes low after edge 2.
  - State is PRESS_WAIT after edge 3.
  - The accumulate takes effect at edge DEBOUNCE_CYCLES+3: LED, Overflow and Acc_pulse are all valid after that edge.
- Any bounce in PRESS_WAIT restarts the full debounce. A glitch shorter than DEBOUNCE_CYCLES never accumulates.
- Re-arm: after release, the button must stay high for DEBOUNCE_CYCLES cycles (plus 2 synchronizer cycles) before IDLE is reached. A press before then returns to HELD with no accumulation.
- Acc_pulse is exactly one cycle wide. At most one pulse per IDLE→HELD traversal.
- SW is sampled combinationally in the accumulate cycle only. SW changes at other times have no effect.
- All outputs are registered, with no combinational path from inputs. Exception: Busy is decoded from the state register.

## Test plan
(Use DEBOUNCE_CYCLES = 4 in all scenarios.)
- Single clean press: Reset, SW = 0x05, hold Accumulate_n low for 20 cycles, then release.
  - After edge 7: LED = 0x05 with a single Acc_pulse.
  - Busy returns to 0 once release_wait completes.
- Bounce rejection: toggle Accumulate_n low 2 cycles, high 1, low 3, high 1, then low and stable.
  - Exactly one accumulate, occurring 7 edges after the final stable low.
  - No pulse during the bounce.
- Overflow and wrap: start from LED = 0xF0 and press with SW = 0x20.
  - LED = 0x10, Overflow = 1.
  - A further press with SW = 0x01 gives LED = 0x11 and Overflow stays 1.
- Clear collision: with LED = 0x33, assert Clear in the exact accumulate cycle with SW = 0x0A.
  - LED = 0x00, Overflow = 0, Acc_pulse = 1.
  - Holding the button longer produces no second add.
- Hold and re-press: hold the button for 100 cycles, release for 2 cycles, press again.
  - Only one accumulate in total, because release debounce did not finish.
  - Release for ≥ 7 cycles, then press again: a second accumulate occurs.
- Reset mid-debounce: assert Reset during PRESS_WAIT while the button stays held.
  - All outputs return to reset values.
  - After Reset deasserts, one accumulate occurs 7 edges later.

Source files
------------

// File: rtl/accumulate_ctrl.sv
// accumulate_ctrl
// Synchronizes and debounces the active-low accumulate push-button. Each
// debounced press adds the 8-bit switch value into a running sum, once.
//
// Ports:
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   Accumulate_n  raw push-button, active-low, asynchronous, bouncy
//   Clear         synchronous, active-high; zeroes sum and overflow
//   SW[7:0]       operand, sampled only in the accumulate cycle
//   LED[7:0]      running sum (registered)
//   Overflow      sticky carry-out-of-bit-7 flag (registered)
//   Acc_pulse     one-cycle strobe on each accumulation (registered)
//   Busy          high whenever the FSM is not IDLE (state decode)
module accumulate_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Accumulate_n,
    input  logic       Clear,
    input  logic [7:0] SW,
    output logic [7:0] LED,
    output logic       Overflow,
    output logic       Acc_pulse,
    output logic       Busy
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       led_q,   led_d;
    logic             ovf_q,   ovf_d;
    logic             pulse_q, pulse_d;

    logic             pressed;
    logic             acc_fire;
    logic [8:0]       sum9;

    assign pressed = ~sync2_q;
    assign sum9    = {1'b0, led_q} + {1'b0, SW};

    // Next-state, debounce counter and accumulator update
    always_comb begin
        sync1_d  = Accumulate_n;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        pulse_d  = 1'b0;
        acc_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HELD;
                    acc_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (acc_fire) begin
            led_d   = sum9[7:0];
            pulse_d = 1'b1;
            if (sum9[8]) begin
                ovf_d = 1'b1;
            end
        end

        // Clear overrides a coincident accumulate; the press is still consumed
        if (Clear) begin
            led_d = 8'h00;
            ovf_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            led_q   <= 8'h00;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    assign LED       = led_q;
    assign Overflow  = ovf_q;
    assign Acc_pulse = pulse_q;
    assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accumulate_ctrl.sv
// Scoreboarded bench for accumulate_ctrl with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected (LED, Overflow, edge number) of every
// accumulation; the monitor pops one entry per observed Acc_pulse.
module tb_accumulate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       acc_n;
    logic       clr;
    logic [7:0] sw;
    logic [7:0] led;
    logic       ovf;
    logic       pulse;
    logic       busy;

    accumulate_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .Accumulate_n(acc_n),
        .Clear       (clr),
        .SW          (sw),
        .LED         (led),
        .Overflow    (ovf),
        .Acc_pulse   (pulse),
        .Busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: value N after the Nth rising edge
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] led;
        logic       ovf;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic o, input int at);
        exp_t e;
        e.led = l;
        e.ovf = o;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: accumulate expected 7 edges after the fall
    task automatic do_press(input logic [7:0] s, input logic [7:0] l, input logic o);
        sw    = s;
        acc_n = 1'b0;
        push(l, o, cyc + 7);
        tick(12);
        acc_n = 1'b1;
        tick(10);
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d LED=0x%0h, expected none", cyc, led);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_led", int'(led), int'(e.led));
                chk("pulse_ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        int e0;
        rst   = 1'b1;
        acc_n = 1'b1;
        clr   = 1'b0;
        sw    = 8'h00;
        tick(3);
        chk("rst_led", int'(led), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick(1);

        // Single clean press, SW changes while held have no effect
        sw    = 8'h05;
        acc_n = 1'b0;
        push(8'h05, 1'b0, cyc + 7);
        tick(3);
        chk("busy_press_wait", int'(busy), 1);
        tick(17);
        sw    = 8'hFF;
        acc_n = 1'b1;
        tick(6);
        chk("busy_release_wait", int'(busy), 1);
        tick(1);
        chk("busy_idle_after_release", int'(busy), 0);
        chk("led_after_press", int'(led), 8'h05);
        tick(3);

        // Bounce: low 2, high 1, low 3, high 1, then stable low
        sw    = 8'h10;
        acc_n = 1'b0; tick(2);
        acc_n = 1'b1; tick(1);
        acc_n = 1'b0; tick(3);
        acc_n = 1'b1; tick(1);
        acc_n = 1'b0;
        push(8'h15, 1'b0, cyc + 7);
        tick(15);
        acc_n = 1'b1;
        tick(10);

        // Overflow and wrap
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clear_led", int'(led), 0);
        do_press(8'hF0, 8'hF0, 1'b0);
        do_press(8'h20, 8'h10, 1'b1);
        chk("ovf_sticky", int'(ovf), 1);
        do_press(8'h01, 8'h11, 1'b1);
        chk("ovf_sticky2", int'(ovf), 1);
        chk("led_wrap", int'(led), 8'h11);

        // Clear in the exact accumulate cycle
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clear_ovf", int'(ovf), 0);
        do_press(8'h33, 8'h33, 1'b0);
        sw    = 8'h0A;
        acc_n = 1'b0;
        e0    = cyc;
        push(8'h00, 1'b0, e0 + 7);
        tick(6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("collide_led", int'(led), 0);
        chk("collide_busy", int'(busy), 1);
        tick(20);
        acc_n = 1'b1;
        tick(10);

        // Hold long, short release, re-press: no second add
        sw    = 8'h02;
        acc_n = 1'b0;
        push(8'h02, 1'b0, cyc + 7);
        tick(100);
        acc_n = 1'b1; tick(2);
        acc_n = 1'b0; tick(20);
        chk("repress_held_busy", int'(busy), 1);
        chk("repress_led", int'(led), 8'h02);
        acc_n = 1'b1;
        tick(10);
        chk("repress_idle", int'(busy), 0);
        do_press(8'h03, 8'h05, 1'b0);

        // Reset during PRESS_WAIT with the button still held
        sw    = 8'h07;
        acc_n = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_led", int'(led), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_pulse", int'(pulse), 0);
        chk("midrst_busy", int'(busy), 0);
        push(8'h07, 1'b0, cyc + 7);
        tick(15);
        acc_n = 1'b1;
        tick(10);

        chk("missing_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
